// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: imem request/response channels, redirect input and
// the instr valid/ready output toward the core.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misalign,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misalign,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited imem requests, in-order {pc, word} FIFO, redirect flush.
// Optional IFETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST    = AW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW-1:0] r_qwptr, r_qrptr;
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_word [FIFO_DEPTH];
    logic [31:0]   r_pcq       [FIFO_DEPTH];
    logic          r_halted;
    logic          r_misalign;

    logic          w_pop;
    logic          w_req_fire;
    logic          w_resp;
    logic          w_enq;
    logic          w_misaligned;
    logic [CW:0]   w_used;
    logic [CW:0]   w_avail;
    logic [CW-1:0] w_out_next;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // A redirect cycle never hands out an instruction: the head is already stale.
    assign bus.instr_valid = !reset && (r_count != '0) && !bus.redirect_valid;
    assign bus.instr       = r_fifo_word[r_rptr];
    assign bus.instr_pc    = r_fifo_pc[r_rptr];
    assign bus.fetch_misalign = r_misalign;

    assign w_pop   = bus.instr_valid && bus.instr_ready;
    assign w_used  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_avail = DEPTH_C + {{CW{1'b0}}, w_pop};

    // Credit covers buffered plus in-flight words, so the FIFO can never overflow.
    assign bus.imem_req_valid = !reset && !r_halted && (w_used < w_avail);
    assign bus.imem_req_addr  = r_fetch_pc;

    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign w_resp     = bus.imem_resp_valid;
    assign w_enq      = w_resp && (r_drop == '0);
    assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(w_resp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_qwptr       <= '0;
            r_qrptr       <= '0;
            r_halted      <= 1'b0;
            r_misalign    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_word[i] <= '0;
                r_pcq[i]       <= '0;
            end
        end else begin
            r_outstanding <= w_out_next;
            if (w_req_fire) begin
                r_pcq[r_qwptr] <= r_fetch_pc;
                r_qwptr        <= inc(r_qwptr);
                r_fetch_pc     <= r_fetch_pc + 32'd4;
            end
            // The pc queue tracks every in-flight request, dropped or not.
            if (w_resp)
                r_qrptr <= inc(r_qrptr);

            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_pc & ~32'h3;
                r_drop     <= w_out_next;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_halted   <= w_misaligned;
                r_misalign <= w_misaligned;
            end else begin
                if (w_resp && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if (w_enq) begin
                    r_fifo_pc[r_wptr]   <= r_pcq[r_qrptr];
                    r_fifo_word[r_wptr] <= bus.imem_resp_data;
                    r_wptr              <= inc(r_wptr);
                end
                if (w_pop)
                    r_rptr <= inc(r_rptr);
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fixed-latency memory model returning ~addr,
// log of delivered {pc, word} compared against hand-derived sequences.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_word[$];
    logic        s_req_valid, s_instr_valid, s_mis;
    logic [31:0] s_req_addr, s_instr, s_instr_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample mid-cycle, let the edge happen, then drive the memory response.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        int          k;
        #3;
        s_req_valid   = bus.imem_req_valid;
        s_req_addr    = bus.imem_req_addr;
        s_instr_valid = bus.instr_valid;
        s_instr       = bus.instr;
        s_instr_pc    = bus.instr_pc;
        s_mis         = bus.fetch_misalign;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        k   = cyc;
        if (acc) n_acc++;
        if (bus.instr_valid && bus.instr_ready) begin
            log_pc.push_back(bus.instr_pc);
            log_word.push_back(bus.instr);
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = 32'hDEAD_BEEF;
        end else begin
            if (acc) begin
                mq_addr.push_back(a);
                mq_due.push_back(k + lat);
            end
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = ~mq_addr[0];
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        bus.imem_resp_valid = 1'b0;
        log_pc.delete();
        log_word.delete();
        n_acc = 0;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] base);
        logic [31:0] pc;
        chk({tag, "_len"}, log_pc.size(), n);
        for (int i = 0; i < n && i < log_pc.size(); i++) begin
            pc = base + 32'(4 * i);
            chk({tag, "_pc"}, log_pc[i], pc);
            chk({tag, "_word"}, log_word[i], ~pc);
        end
    endtask

    task automatic redirect_step(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b1;

        // Reset state, with garbage responses arriving during reset.
        do_reset();
        chk("rst_req_valid", s_req_valid, 0);
        chk("rst_instr_valid", s_instr_valid, 0);
        chk("rst_misalign", s_mis, 0);
        chk("rst_instr", s_instr, 0);
        chk("rst_instr_pc", s_instr_pc, 0);

        // Streaming, 1-cycle memory.
        step();
        chk("t1_req0_valid", s_req_valid, 1);
        chk("t1_req0_addr", s_req_addr, 32'h0);
        step();
        chk("t1_req1_addr", s_req_addr, 32'h4);
        chk("t1_iv_c2", s_instr_valid, 0);
        step();
        chk("t1_req2_addr", s_req_addr, 32'h8);
        chk("t1_iv_c3", s_instr_valid, 1);
        chk("t1_pc_c3", s_instr_pc, 32'h0);
        repeat (5) step();
        check_stream("t1", 6, 32'h0);

        // Downstream back-pressure from reset; reset lands mid-stream.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("t2_req_count", n_acc, 2);
        chk("t2_req_idle", s_req_valid, 0);
        bus.instr_ready = 1'b1;
        repeat (8) step();
        check_stream("t2", 8, 32'h0);

        // Memory back-pressure: request held stable at 0x8.
        do_reset();
        step();
        step();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", s_req_valid, 1);
            chk("t3_hold_addr", s_req_addr, 32'h8);
        end
        bus.imem_req_ready = 1'b1;
        step();
        chk("t3_rel_addr", s_req_addr, 32'h8);
        step();
        chk("t3_next_addr", s_req_addr, 32'hC);
        repeat (4) step();
        check_stream("t3", 6, 32'h0);

        // 3-cycle memory, two in flight, redirect drops both.
        lat = 3;
        do_reset();
        step();
        step();
        redirect_step(32'h100);
        chk("t4_redir_iv", s_instr_valid, 0);
        chk("t4_redir_req", s_req_valid, 0);
        step();
        chk("t4_nocredit", s_req_valid, 0);
        step();
        chk("t4_new_valid", s_req_valid, 1);
        chk("t4_new_addr", s_req_addr, 32'h100);
        repeat (7) step();
        check_stream("t4", 2, 32'h100);

        // Redirect while a request is accepted and a response returns.
        lat = 1;
        do_reset();
        step();
        redirect_step(32'h200);
        chk("t5_same_req", s_req_valid, 1);
        chk("t5_same_addr", s_req_addr, 32'h4);
        step();
        chk("t5_new_addr", s_req_addr, 32'h200);
        repeat (5) step();
        check_stream("t5", 4, 32'h200);

        // Redirect in steady state hides a valid FIFO head.
        log_pc.delete();
        log_word.delete();
        redirect_step(32'h300);
        chk("t5b_redir_iv", s_instr_valid, 0);
        step();
        chk("t5b_new_addr", s_req_addr, 32'h300);
        repeat (5) step();
        check_stream("t5b", 4, 32'h300);

        // Fetch PC wraps past the top of the address space.
        log_pc.delete();
        log_word.delete();
        redirect_step(32'hFFFF_FFF8);
        step();
        chk("t6_addr0", s_req_addr, 32'hFFFF_FFF8);
        step();
        chk("t6_addr1", s_req_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_addr2", s_req_addr, 32'h0);
        repeat (2) step();
        check_stream("t6", 3, 32'hFFFF_FFF8);

        // Misaligned redirect target.
        log_pc.delete();
        log_word.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
        redirect_step(32'h102);
        n_acc = 0;
        step();
        chk("t7_mis_set", s_mis, 1);
        repeat (4) step();
        chk("t7_halt_reqs", n_acc, 0);
        chk("t7_halt_valid", s_req_valid, 0);
        log_pc.delete();
        log_word.delete();
        redirect_step(32'h200);
        step();
        chk("t7_mis_clr", s_mis, 0);
        chk("t7_resume_valid", s_req_valid, 1);
        chk("t7_resume_addr", s_req_addr, 32'h200);
        repeat (4) step();
        check_stream("t7", 3, 32'h200);
`else
        redirect_step(32'h102);
        step();
        chk("t7_mis_tied", s_mis, 0);
        chk("t7_aligned_valid", s_req_valid, 1);
        chk("t7_aligned_addr", s_req_addr, 32'h100);
        repeat (4) step();
        check_stream("t7", 3, 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
